// File: rtl/shift_reg_rs_pkg.sv
// Shared op encodings and cnt width helper for the shift_reg_rs block.
`timescale 1ns/1ps
package shift_reg_rs_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5
  } op_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_rs_if.sv
// Control/data bundle of shift_reg_rs; parity member exists only with SHIFT_REG_RS_PARITY_EN.
`timescale 1ns/1ps
interface shift_reg_rs_if
  import shift_reg_rs_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CW = cnt_w(WIDTH);

  logic             set_n;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             si;
  logic [WIDTH-1:0] q;
  logic             so;
  logic [CW-1:0]    cnt;
  logic             drained;
`ifdef SHIFT_REG_RS_PARITY_EN
  logic             parity;

  modport master (output set_n, op, d, si, input q, so, cnt, drained, parity);
  modport slave  (input set_n, op, d, si, output q, so, cnt, drained, parity);
`else
  modport master (output set_n, op, d, si, input q, so, cnt, drained);
  modport slave  (input set_n, op, d, si, output q, so, cnt, drained);
`endif
endinterface

// File: rtl/shift_reg_rs_dff_rs_en.sv
// 1-bit cell: async active-low reset to RST_BIT, sync active-low set, enable.
// Latency 1 cycle; no backpressure.
`timescale 1ns/1ps
module dff_rs_en #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_n_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);
  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_BIT;
    end else if (!set_n_i) begin
      q_q <= 1'b1;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/shift_reg_rs.sv
// Shift/rotate/load register with shift counter; optional parity via SHIFT_REG_RS_PARITY_EN.
// Latency 1 cycle for q/so/cnt, drained combinational from cnt; no backpressure.
`timescale 1ns/1ps
module shift_reg_rs
  import shift_reg_rs_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  shift_reg_rs_if.slave bus
);
  localparam int            CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_nxt;
  logic             en;
  logic             so_q, so_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    q_d   = q_q;
    so_d  = so_q;
    cnt_d = cnt_q;
    en    = 1'b0;
    case (bus.op)
      OP_LOAD: begin
        q_d   = bus.d;
        so_d  = 1'b0;
        cnt_d = '0;
        en    = 1'b1;
      end
      OP_SHL: begin
        q_d   = {q_q[WIDTH-2:0], bus.si};
        so_d  = q_q[WIDTH-1];
        cnt_d = cnt_inc;
        en    = 1'b1;
      end
      OP_SHR: begin
        q_d   = {bus.si, q_q[WIDTH-1:1]};
        so_d  = q_q[0];
        cnt_d = cnt_inc;
        en    = 1'b1;
      end
      OP_ROL: begin
        q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        so_d = q_q[WIDTH-1];
        en   = 1'b1;
      end
      OP_ROR: begin
        q_d  = {q_q[0], q_q[WIDTH-1:1]};
        so_d = q_q[0];
        en   = 1'b1;
      end
      default: ;
    endcase
    // set overrides any op; q bits see it through the cell's own set input
    if (!bus.set_n) begin
      so_d  = 1'b0;
      cnt_d = '0;
    end
    q_nxt = bus.set_n ? q_d : '1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_rs_en #(
      .RST_BIT (RST_VAL[i])
    ) u_bit (
      .clk     (clk),
      .rst_n   (reset_n),
      .set_n_i (bus.set_n),
      .en_i    (en),
      .d_i     (q_d[i]),
      .q_o     (q_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      so_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      so_q  <= so_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SHIFT_REG_RS_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= ^RST_VAL;
    end else begin
      parity_q <= ^q_nxt;
    end
  end

  assign bus.parity = parity_q;
`else
  logic unused_q_nxt;
  assign unused_q_nxt = ^q_nxt;
`endif

  assign bus.q       = q_q;
  assign bus.so      = so_q;
  assign bus.cnt     = cnt_q;
  assign bus.drained = (cnt_q == CNT_MAX);
endmodule

// File: doc/shift_reg_rs.md
SHIFT_REG_RS -- requirements
Module: shift_reg_rs

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal 2..32).
REQ-002 The block SHALL have parameter RST_VAL, default 0, meaning the WIDTH-bit value loaded by asynchronous reset.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 The block SHALL have port set_n  input  1  synchronous active-low set, forcing q to all ones.
REQ-006 The block SHALL have port op  input  3  operation code.
REQ-007 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-008 The block SHALL have port si  input  1  serial input for shifts.
REQ-009 The block SHALL have port q  output  WIDTH  register contents.
REQ-010 The block SHALL have port so  output  1  last bit shifted out, registered.
REQ-011 The block SHALL have port cnt  output  clog2(WIDTH+1)  count of logical shifts since the last load or set.
REQ-012 The block SHALL have port drained  output  1  high when cnt equals WIDTH.

Function
REQ-013 op encodings SHALL be 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, and 6-7 are treated as HOLD.
REQ-014 All updates SHALL occur on the rising clk edge with one-cycle latency: q, so and cnt reflect op on the next edge.
REQ-015 Priority SHALL be reset_n (async) > set_n > op.
REQ-016 set_n low SHALL set q to all ones, cnt to 0 and so to 0, regardless of op.
REQ-017 LOAD SHALL set q to d, cnt to 0 and so to 0.
REQ-018 SHL SHALL set q to {q[WIDTH-2:0], si} and so to the old q[WIDTH-1].
REQ-019 SHR SHALL set q to {si, q[WIDTH-1:1]} and so to the old q[0].
REQ-020 ROL and ROR SHALL rotate q by one bit, ignore si, set so to the rotated-out bit, and leave cnt unchanged.
REQ-021 SHL and SHR SHALL increment cnt, saturating at WIDTH with no wrap.
REQ-022 HOLD SHALL keep q, so and cnt unchanged.
REQ-023 drained SHALL be combinational from cnt (cnt == WIDTH) with no extra latency.

Reset
REQ-024 On reset_n low, q SHALL take RST_VAL, so 0, cnt 0 and drained 0 immediately, independent of clk.
REQ-025 While reset_n is low, clock edges SHALL have no effect; the first edge after deassertion executes set_n/op normally.
REQ-026 Reset asserted mid-shift-sequence SHALL abandon the sequence with no residual state.

Configuration
REQ-027 With SHIFT_REG_RS_PARITY_EN defined, the block SHALL add output parity (1 bit, registered, XOR of the next q), updated in the same cycle as q and reset to the XOR of RST_VAL.
REQ-028 Without SHIFT_REG_RS_PARITY_EN, the parity port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package shift_reg_rs_pkg SHALL hold the op encoding constants (OP_HOLD..OP_ROR) and the cnt width function.
REQ-030 One sub-module, dff_rs_en (1-bit cell: async active-low reset to a per-bit value, sync set, enable, d), SHALL be instantiated WIDTH times for q.
REQ-031 The next-state mux, so and cnt logic SHALL reside in shift_reg_rs.

Verification (WIDTH=8, RST_VAL=0)
REQ-032 reset_n=0 at t=2.5 ns between edges -> q=00, cnt=0, so=0 immediately; edges with op=LOAD are ignored while reset_n is low.
REQ-033 LOAD d=A5, then 8x SHR with si=0 -> so sequence 1,0,1,0,0,1,0,1; q=00; cnt=8; drained=1; a 9th SHR leaves cnt=8.
REQ-034 LOAD 81, then ROL -> q=03, so=1, cnt=0; ROR -> q=81, so=1.
REQ-035 set_n=0 with op=LOAD d=3C -> q=FF, cnt=0; releasing set_n, then SHL si=0 -> q=FE, so=1, cnt=1.
REQ-036 LOAD 0F, 3x SHL, then reset_n pulse -> q=00, cnt=0; next LOAD F0 -> q=F0; with SHIFT_REG_RS_PARITY_EN, parity=0 after both LOAD 0F and LOAD F0, and parity=1 after LOAD 01.
